// File: rtl/pc_update.sv
// Y86-64 PC-update / processor-status stage: next-PC select, status FSM, retired counter.
// Optional trace outputs (prev_pc, br_taken) are enabled with `define PC_UPDATE_TRACE_EN.
module pc_update #(
    parameter logic [63:0] RESET_PC  = 64'd420,
    parameter logic [63:0] IMEM_SIZE = 64'd1024,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_en,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [63:0]      valC,
    input  logic [63:0]      valP,
    input  logic [63:0]      valM,
    input  logic             cnd,
    input  logic             halt,
    input  logic             imem_error,
    input  logic             instr_valid,
    input  logic             dmem_error,
    output logic [63:0]      PC,
    output logic [2:0]       stat,
    output logic             running,
    output logic             pc_oob,
`ifdef PC_UPDATE_TRACE_EN
    output logic [63:0]      prev_pc,
    output logic             br_taken,
`endif
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned PC_W = 64;
    localparam int unsigned ST_W = 3;

    // State codes double as the architectural stat encoding.
    localparam logic [ST_W-1:0] RUN      = 3'd1;
    localparam logic [ST_W-1:0] STOP_HLT = 3'd2;
    localparam logic [ST_W-1:0] STOP_ADR = 3'd3;
    localparam logic [ST_W-1:0] STOP_INS = 3'd4;

    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    logic [ST_W-1:0]  state, state_nx;
    logic [PC_W-1:0]  pc_nx, next_pc;
    logic [CNT_W-1:0] retired_nx, retired_inc;
    logic             running_nx, oob_nx, commit;

    // Next-PC selection from fetch/execute/memory results.
    always_comb begin
        next_pc = valP;
        case (icode)
            I_JXX:   if (ifun == 4'h0 || cnd) next_pc = valC;
            I_CALL:  next_pc = valC;
            I_RET:   next_pc = valM;
            default: next_pc = valP;
        endcase
    end

    assign retired_inc = (retired == {CNT_W{1'b1}}) ? retired : retired + CNT_W'(1);

    // Status FSM and register next values; errors outrank invalid, which outranks halt.
    always_comb begin
        state_nx   = state;
        pc_nx      = PC;
        retired_nx = retired;
        running_nx = running;
        oob_nx     = pc_oob;
        commit     = 1'b0;
        if (state == RUN && step_en) begin
            if (imem_error || dmem_error) begin
                state_nx   = STOP_ADR;
                running_nx = 1'b0;
            end else if (!instr_valid) begin
                state_nx   = STOP_INS;
                running_nx = 1'b0;
            end else if (halt) begin
                state_nx   = STOP_HLT;
                running_nx = 1'b0;
                retired_nx = retired_inc;
                commit     = 1'b1;
            end else begin
                pc_nx      = next_pc;
                oob_nx     = (next_pc >= IMEM_SIZE);
                retired_nx = retired_inc;
                commit     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            PC      <= RESET_PC;
            retired <= '0;
            running <= 1'b1;
            pc_oob  <= 1'b0;
        end else begin
            state   <= state_nx;
            PC      <= pc_nx;
            retired <= retired_nx;
            running <= running_nx;
            pc_oob  <= oob_nx;
        end
    end

    assign stat = state;

`ifdef PC_UPDATE_TRACE_EN
    // Trace of the last committed step: its PC and whether control flow diverged from valP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_pc  <= '0;
            br_taken <= 1'b0;
        end else if (commit) begin
            prev_pc  <= PC;
            br_taken <= (icode == I_JXX || icode == I_CALL || icode == I_RET) && (next_pc != valP);
        end
    end
`endif

endmodule

// File: tb/tb_pc_update.sv
// Scoreboard bench for pc_update: driver pushes model predictions, monitor pops and compares.
module tb_pc_update;

    localparam int unsigned CW = 4;
    localparam int unsigned CNT_MAX = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          step_en = 1'b0;
    logic [3:0]    icode = '0, ifun = '0;
    logic [63:0]   valC = '0, valP = '0, valM = '0;
    logic          cnd = 1'b0, halt = 1'b0, imem_error = 1'b0, instr_valid = 1'b1, dmem_error = 1'b0;
    logic [63:0]   PC;
    logic [2:0]    stat;
    logic          running, pc_oob;
    logic [CW-1:0] retired;
`ifdef PC_UPDATE_TRACE_EN
    logic [63:0]   prev_pc;
    logic          br_taken;
`endif

    pc_update #(.RESET_PC(64'd420), .IMEM_SIZE(64'd1024), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .step_en(step_en), .icode(icode), .ifun(ifun),
        .valC(valC), .valP(valP), .valM(valM), .cnd(cnd), .halt(halt),
        .imem_error(imem_error), .instr_valid(instr_valid), .dmem_error(dmem_error),
        .PC(PC), .stat(stat), .running(running), .pc_oob(pc_oob),
`ifdef PC_UPDATE_TRACE_EN
        .prev_pc(prev_pc), .br_taken(br_taken),
`endif
        .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [2:0]  stat;
        logic        run;
        logic        oob;
        logic [63:0] ret;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Architectural model: status 1..4, PC, committed-instruction count.
    logic [63:0] m_pc;
    int          m_stat;
    int          m_cnt;
    logic        m_oob;

    function automatic exp_t snap();
        exp_t e;
        e.pc   = m_pc;
        e.stat = 3'(m_stat);
        e.run  = (m_stat == 1);
        e.oob  = m_oob;
        e.ret  = (m_cnt > int'(CNT_MAX)) ? 64'(CNT_MAX) : 64'(m_cnt);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", PC, e.pc);
                chk("stat", 64'(stat), 64'(e.stat));
                chk("running", 64'(running), 64'(e.run));
                chk("pc_oob", 64'(pc_oob), 64'(e.oob));
                chk("retired", 64'(retired), e.ret);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step_en = 1'b1;
        icode = 4'h1;
        valP = {32'h0, $urandom};
        m_pc = 64'd420; m_stat = 1; m_cnt = 0; m_oob = 1'b0;
        q.push_back(snap());
        @(negedge clk);
        rst = 1'b0;
        step_en = 1'b0;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] c,
                         input logic [63:0] p, input logic [63:0] m, input logic cd,
                         input logic hl, input logic ie, input logic iv, input logic de,
                         input logic se);
        logic [63:0] tgt;
        @(negedge clk);
        icode = ic; ifun = fn; valC = c; valP = p; valM = m; cnd = cd;
        halt = hl; imem_error = ie; instr_valid = iv; dmem_error = de; step_en = se;
        if (m_stat == 1 && se) begin
            if (ie || de) m_stat = 3;
            else if (!iv) m_stat = 4;
            else if (hl) begin
                m_stat = 2;
                m_cnt++;
            end else begin
                // Jumps taken when unconditional or condition true; call to valC; ret to valM.
                if (ic == 4'd8 || (ic == 4'd7 && (fn == 4'd0 || cd))) tgt = c;
                else if (ic == 4'd9) tgt = m;
                else tgt = p;
                m_pc = tgt;
                m_oob = (tgt >= 64'd1024);
                m_cnt++;
            end
        end
        q.push_back(snap());
    endtask

    function automatic logic [63:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return {52'h0, 12'($urandom_range(0, 2047))};
        return {$urandom, $urandom};
    endfunction

    initial begin : driver
        do_reset();
        drive(4'h1, 4'h0, 64'h0, 64'd421, 64'h0, 0, 0, 0, 1, 0, 1);
        drive(4'h7, 4'h1, 64'hFF, 64'h1EC, 64'h0, 0, 0, 0, 1, 0, 1);
        drive(4'h7, 4'h1, 64'hFF, 64'h1EC, 64'h0, 1, 0, 0, 1, 0, 1);
        drive(4'h7, 4'h0, 64'h130, 64'h1EC, 64'h0, 0, 0, 0, 1, 0, 1);
        drive(4'h8, 4'h0, 64'h48, 64'h139, 64'h0, 0, 0, 0, 1, 0, 1);
        drive(4'h9, 4'h0, 64'h0, 64'h49, 64'h222, 0, 0, 0, 1, 0, 1);
        drive(4'h1, 4'h0, 64'h0, 64'h300, 64'h0, 0, 0, 0, 1, 0, 0);
        drive(4'h1, 4'h0, 64'h0, 64'd500, 64'h0, 0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(4'h1, 4'h0, 64'h0, 64'd600, 64'h0, 0, 0, 0, 1, 0, 1);
        do_reset();
        drive(4'h0, 4'h0, 64'h0, 64'h1A5, 64'h0, 0, 1, 0, 1, 0, 1);
        for (int i = 0; i < 2; i++) drive(4'h1, 4'h0, 64'h0, 64'd700, 64'h0, 0, 0, 0, 1, 0, 1);
        do_reset();
        drive(4'h1, 4'h0, 64'h0, 64'd430, 64'h0, 0, 0, 0, 0, 0, 1);
        drive(4'h1, 4'h0, 64'h0, 64'd440, 64'h0, 0, 0, 0, 1, 0, 1);
        do_reset();
        drive(4'h5, 4'h0, 64'h0, 64'd450, 64'h0, 0, 0, 0, 1, 1, 1);
        do_reset();
        drive(4'h1, 4'h0, 64'h0, 64'd1024, 64'h0, 0, 0, 0, 1, 0, 1);
        drive(4'h1, 4'h0, 64'h0, 64'd1023, 64'h0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 20; i++)
            drive(4'h1, 4'h0, 64'h0, 64'(1030 + i), 64'h0, 0, 0, 0, 1, 0, 1);
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (m_stat != 1 && $urandom_range(0, 3) == 0) do_reset();
            drive(4'($urandom_range(0, 11)), 4'($urandom_range(0, 6)), rnd_addr(), rnd_addr(),
                  rnd_addr(), 1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 39) != 0),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0));
        end
        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_update.md
Name: pc_update

Overview:
- Sequential PC-update and processor-status stage for the Y86-64 core.
- Sits directly upstream of fetch and owns the architectural PC register that drives fetch's PC input.
- Once per instruction step it selects the next PC from the fetch, execute and memory results (valP, valC, valM, cnd).
- Runs the machine status FSM (AOK/HLT/ADR/INS) and freezes the PC when a halt or exception occurs.

Parameters:
- RESET_PC, 64'd420: PC loaded on reset (program base address).
- IMEM_SIZE, 1024: instruction memory size in bytes; a next PC >= IMEM_SIZE sets pc_oob.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  single system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- step_en  in  1  advance one instruction on this edge; fetch/decode/execute/memory results are stable.
- icode  in  4  from fetch.
- ifun  in  4  from fetch.
- valC  in  64  from fetch.
- valP  in  64  from fetch.
- valM  in  64  from memory stage.
- cnd  in  1  condition result from execute.
- halt  in  1  from fetch.
- imem_error  in  1  from fetch.
- instr_valid  in  1  from fetch.
- dmem_error  in  1  from memory stage.
- PC  out  64  current PC to fetch.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- running  out  1  high only in state RUN.
- pc_oob  out  1  registered; last committed PC >= IMEM_SIZE.
- retired  out  CNT_W  count of committed instructions.

Behaviour:
- Reset (async, immediate):
  - PC=RESET_PC, stat=1, state=RUN, running=1, pc_oob=0, retired=0.
  - Reset asserted mid-run discards the pending step; a step_en coincident with rst is ignored.
- FSM states: RUN, STOP_HLT, STOP_ADR, STOP_INS. The three STOP states are terminal until rst.
- In RUN with step_en=1, status is evaluated by priority:
  1. imem_error or dmem_error: go to STOP_ADR, stat=3, PC unchanged, retired unchanged.
  2. instr_valid=0: go to STOP_INS, stat=4, PC unchanged, retired unchanged.
  3. halt=1: go to STOP_HLT, stat=2, PC unchanged, retired+1 (halt commits).
  4. Otherwise stay in RUN, stat=1, PC<=next_pc, retired+1.
- next_pc selection:
  - icode 7: valC if (ifun==0 or cnd==1), else valP. A jmp is taken regardless of cnd.
  - icode 8 (call): valC.
  - icode 9 (ret): valM.
  - All other icodes: valP.
- Arithmetic and bounds:
  - PC is unsigned 64-bit with no bounds clamping; fetch reports out-of-range addresses via imem_error on the next step.
  - pc_oob is registered with the PC, set when next_pc >= IMEM_SIZE.
- Counter: retired saturates at all-ones; it does not wrap.
- In RUN with step_en=0: all registers hold.
- In any STOP state: step_en is ignored; PC, stat and retired hold; running=0.
- Outputs are registered with zero combinational input-to-output paths. PC is valid to fetch one clk edge after the step.

Optional Feature:
- Macro: PC_UPDATE_TRACE_EN.
- Defined:
  - Adds outputs prev_pc (64) and br_taken (1), both reset to 0.
  - On every committed step, prev_pc <= old PC.
  - br_taken <= 1 when icode is 7, 8 or 9 and next_pc != valP; otherwise 0.
  - Both hold in STOP states.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset then step: rst=1 then 0, step_en=1, icode=1, valP=421 -> after 1 edge PC=421, stat=1, retired=1.
- Conditional jump: icode=7, ifun=1, cnd=0, valC=0xFF, valP=0x1EC -> PC=0x1EC; repeat with cnd=1 -> PC=0xFF; ifun=0, cnd=0 -> PC=valC.
- Call/ret: icode=8, valC=0x48 -> PC=0x48; then icode=9, valM=0x222 -> PC=0x222, retired increments by 2.
- Error priority: imem_error=1, instr_valid=0, halt=1 on the same step -> stat=3, PC unchanged, retired unchanged; further steps with icode=1 leave everything frozen.
- Halt: halt=1, valP=0x1A5 -> stat=2, running=0, PC unchanged, retired+1; assert rst mid-hold -> PC=420, stat=1, running=1.
- Boundary: valP=1024 -> pc_oob=1, PC=1024, stat=1; with CNT_W=4, 20 nop steps -> retired saturates at 15.
